// File: rtl/time_target_router_pkg.sv
// Shared types, BCD limits and range-check helpers for the time/alarm write router.
// Optional alarm arming is enabled by defining TIME_TARGET_ALARM_ARM_EN.
package time_target_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_EDIT_TIME   = 3'd1,
        ST_EDIT_ALARM  = 3'd2,
        ST_CONFLICT    = 3'd3,
        ST_COMMIT_TIME = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        MODE_IDLE     = 2'd0,
        MODE_TIME     = 2'd1,
        MODE_ALARM    = 2'd2,
        MODE_CONFLICT = 2'd3
    } mode_t;

    localparam logic [7:0] HOUR_MAX      = 8'h23;
    localparam logic [3:0] HOUR_TENS_MAX = 4'd2;
    localparam logic [3:0] MIN_TENS_MAX  = 4'd5;
    localparam logic [3:0] UNITS_MAX     = 4'd9;

    function automatic logic bcd_hours_ok(input logic [7:0] h);
        return (h[7:4] <= HOUR_TENS_MAX) && (h[3:0] <= UNITS_MAX) && (h <= HOUR_MAX);
    endfunction

    function automatic logic bcd_minutes_ok(input logic [7:0] m);
        return (m[7:4] <= MIN_TENS_MAX) && (m[3:0] <= UNITS_MAX);
    endfunction

    // The commit cycle is still part of a time edit from the user's point of view.
    function automatic mode_t mode_of(input state_t s);
        case (s)
            ST_EDIT_TIME, ST_COMMIT_TIME: return MODE_TIME;
            ST_EDIT_ALARM:                return MODE_ALARM;
            ST_CONFLICT:                  return MODE_CONFLICT;
            default:                      return MODE_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/time_target_router_if.sv
// Bus between the user-input side (master) and the time/alarm router (slave).
// Arming signals exist only when TIME_TARGET_ALARM_ARM_EN is defined.
interface time_target_router_if #(
    parameter int NUM_ALARMS = 2,
    parameter int SEL_W      = 3
);
    logic [7:0]              hours;
    logic [7:0]              minutes;
    logic                    set_time;
    logic                    set_alarm;
    logic [SEL_W-1:0]        alarm_sel;
    logic [7:0]              hours_set;
    logic [7:0]              minutes_set;
    logic                    time_load;
    logic [8*NUM_ALARMS-1:0] alarm_hours;
    logic [8*NUM_ALARMS-1:0] alarm_minutes;
    logic [1:0]              edit_mode;
    logic                    bad_value;
`ifdef TIME_TARGET_ALARM_ARM_EN
    logic [NUM_ALARMS-1:0]   alarm_armed;
    logic [NUM_ALARMS-1:0]   disarm;
`endif

    modport master (
        output hours, minutes, set_time, set_alarm, alarm_sel,
`ifdef TIME_TARGET_ALARM_ARM_EN
        output disarm,
        input  alarm_armed,
`endif
        input  hours_set, minutes_set, time_load, alarm_hours, alarm_minutes,
        input  edit_mode, bad_value
    );

    modport slave (
        input  hours, minutes, set_time, set_alarm, alarm_sel,
`ifdef TIME_TARGET_ALARM_ARM_EN
        input  disarm,
        output alarm_armed,
`endif
        output hours_set, minutes_set, time_load, alarm_hours, alarm_minutes,
        output edit_mode, bad_value
    );

endinterface

// File: rtl/time_target_router_bcd_time_check.sv
// Combinational BCD range check for an hours/minutes pair; shared with the timekeeper.
module bcd_time_check
    import time_target_pkg::*;
(
    input  logic [7:0] hours,
    input  logic [7:0] minutes,
    output logic       valid
);

    assign valid = bcd_hours_ok(hours) && bcd_minutes_ok(minutes);

endmodule

// File: rtl/time_target_router.sv
// Routes user-edited BCD hours/minutes to the time-load register or one alarm channel.
// Define TIME_TARGET_ALARM_ARM_EN to add per-channel alarm arming with disarm inputs.
module time_target_router
    import time_target_pkg::*;
#(
    parameter int NUM_ALARMS = 2,
    parameter int SEL_W      = 3
) (
    input  logic                 MHz_25,
    input  logic                 reset_n,
    time_target_router_if.slave  bus
);

    state_t                  state;
    state_t                  next_state;
    logic [SEL_W-1:0]        ch;
    logic                    valid;
    logic                    sel_in_range;
    logic                    time_write;
    logic                    alarm_write;
    logic                    time_load_d;
    mode_t                   edit_mode_d;
    logic                    bad_d;

    logic [7:0]              hours_set_q;
    logic [7:0]              minutes_set_q;
    logic                    time_load_q;
    logic [1:0]              edit_mode_q;
    logic                    bad_q;
    logic [8*NUM_ALARMS-1:0] alarm_hours_q;
    logic [8*NUM_ALARMS-1:0] alarm_minutes_q;

    bcd_time_check u_check (
        .hours   (bus.hours),
        .minutes (bus.minutes),
        .valid   (valid)
    );

    // Full-width compare so out-of-range selects in the spare code space are caught.
    assign sel_in_range = int'(bus.alarm_sel) < NUM_ALARMS;

    always_ff @(posedge MHz_25 or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (bus.set_time && bus.set_alarm) next_state = ST_CONFLICT;
                else if (bus.set_time)             next_state = ST_EDIT_TIME;
                else if (bus.set_alarm)            next_state = sel_in_range ? ST_EDIT_ALARM : ST_CONFLICT;
            end
            ST_EDIT_TIME: begin
                if (bus.set_alarm)     next_state = ST_CONFLICT;
                else if (!bus.set_time) next_state = ST_COMMIT_TIME;
            end
            ST_COMMIT_TIME: next_state = ST_IDLE;
            ST_EDIT_ALARM: begin
                if (bus.set_time)       next_state = ST_CONFLICT;
                else if (!bus.set_alarm) next_state = ST_IDLE;
            end
            ST_CONFLICT: begin
                if (!bus.set_time && !bus.set_alarm) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Registered outputs are computed from next_state so they line up with the state register.
    always_comb begin
        time_load_d = (next_state == ST_COMMIT_TIME);
        edit_mode_d = mode_of(next_state);
        time_write  = (state == ST_EDIT_TIME) && valid;
        alarm_write = (state == ST_EDIT_ALARM) && valid;
        bad_d       = bad_q;
        if (next_state == ST_IDLE)
            bad_d = 1'b0;
        else if (state == ST_EDIT_TIME || state == ST_EDIT_ALARM)
            bad_d = !valid;
    end

    always_ff @(posedge MHz_25 or negedge reset_n) begin
        if (!reset_n) begin
            hours_set_q     <= '0;
            minutes_set_q   <= '0;
            time_load_q     <= 1'b0;
            edit_mode_q     <= '0;
            bad_q           <= 1'b0;
            alarm_hours_q   <= '0;
            alarm_minutes_q <= '0;
            ch              <= '0;
        end else begin
            time_load_q <= time_load_d;
            edit_mode_q <= edit_mode_d;
            bad_q       <= bad_d;
            if (state == ST_IDLE && next_state == ST_EDIT_ALARM)
                ch <= bus.alarm_sel;
            if (time_write) begin
                hours_set_q   <= bus.hours;
                minutes_set_q <= bus.minutes;
            end
            for (int k = 0; k < NUM_ALARMS; k++) begin
                if (alarm_write && ch == SEL_W'(k)) begin
                    alarm_hours_q[8*k +: 8]   <= bus.hours;
                    alarm_minutes_q[8*k +: 8] <= bus.minutes;
                end
            end
        end
    end

`ifdef TIME_TARGET_ALARM_ARM_EN
    logic                  wrote_any;
    logic                  arm_fire;
    logic [NUM_ALARMS-1:0] armed_q;

    // A channel arms only if this edit stored at least one valid value into it.
    assign arm_fire = (state == ST_EDIT_ALARM) && (next_state == ST_IDLE) && (wrote_any || alarm_write);

    always_ff @(posedge MHz_25 or negedge reset_n) begin
        if (!reset_n) begin
            wrote_any <= 1'b0;
            armed_q   <= '0;
        end else begin
            if (state == ST_IDLE)
                wrote_any <= 1'b0;
            else if (alarm_write)
                wrote_any <= 1'b1;
            for (int k = 0; k < NUM_ALARMS; k++) begin
                if (bus.disarm[k])
                    armed_q[k] <= 1'b0;
                else if (arm_fire && ch == SEL_W'(k))
                    armed_q[k] <= 1'b1;
            end
        end
    end

    assign bus.alarm_armed = armed_q;
`endif

    assign bus.hours_set     = hours_set_q;
    assign bus.minutes_set   = minutes_set_q;
    assign bus.time_load     = time_load_q;
    assign bus.edit_mode     = edit_mode_q;
    assign bus.bad_value     = bad_q;
    assign bus.alarm_hours   = alarm_hours_q;
    assign bus.alarm_minutes = alarm_minutes_q;

endmodule

// File: tb/tb_time_target_router.sv
// Directed self-checking bench for time_target_router (NUM_ALARMS=2, SEL_W=3).
module tb_time_target_router;

    logic MHz_25;
    logic reset_n;
    int   compared;
    int   mismatched;
    int   load_pulses;

    time_target_router_if #(.NUM_ALARMS(2), .SEL_W(3)) bus ();

    time_target_router #(.NUM_ALARMS(2), .SEL_W(3)) dut (
        .MHz_25  (MHz_25),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial MHz_25 = 1'b0;
    always #20 MHz_25 = ~MHz_25;

    always @(negedge MHz_25) begin
        if (reset_n && bus.time_load === 1'b1) load_pulses++;
    end

    task automatic tick();
        @(posedge MHz_25);
        #1;
    endtask

    task automatic drive(input logic st, input logic sa, input logic [2:0] sel,
                         input logic [7:0] h, input logic [7:0] m);
        bus.set_time  = st;
        bus.set_alarm = sa;
        bus.alarm_sel = sel;
        bus.hours     = h;
        bus.minutes   = m;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
        #50;
        compared++;
        if (bus.hours_set !== 8'h00 || bus.minutes_set !== 8'h00) begin
            mismatched++;
            $display("[TB] FAIL reset_time_regs: got %h/%h expected 00/00", bus.hours_set, bus.minutes_set);
        end
        compared++;
        if (bus.alarm_hours !== 16'h0000 || bus.alarm_minutes !== 16'h0000) begin
            mismatched++;
            $display("[TB] FAIL reset_alarm_regs: got %h/%h expected 0000/0000", bus.alarm_hours, bus.alarm_minutes);
        end
        compared++;
        if (bus.time_load !== 1'b0 || bus.edit_mode !== 2'd0 || bus.bad_value !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_status: got load=%b mode=%0d bad=%b expected 0/0/0",
                     bus.time_load, bus.edit_mode, bus.bad_value);
        end
        #20 reset_n = 1'b1;
        tick();
    endtask

    task automatic test_time_edit();
        drive(1'b1, 1'b0, 3'd0, 8'h09, 8'h30);
        tick();
        compared++;
        if (bus.edit_mode !== 2'd1 || bus.hours_set !== 8'h00) begin
            mismatched++;
            $display("[TB] FAIL time_entry: got mode=%0d hours_set=%h expected 1/00", bus.edit_mode, bus.hours_set);
        end
        tick();
        compared++;
        if (bus.hours_set !== 8'h09 || bus.minutes_set !== 8'h30) begin
            mismatched++;
            $display("[TB] FAIL time_first_sample: got %h/%h expected 09/30", bus.hours_set, bus.minutes_set);
        end
        tick(); tick(); tick();
        compared++;
        if (bus.time_load !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL time_no_early_load: got %b expected 0", bus.time_load);
        end
        bus.set_time = 1'b0;
        tick();
        compared++;
        if (bus.time_load !== 1'b1 || bus.edit_mode !== 2'd1) begin
            mismatched++;
            $display("[TB] FAIL time_commit: got load=%b mode=%0d expected 1/1", bus.time_load, bus.edit_mode);
        end
        tick();
        compared++;
        if (bus.time_load !== 1'b0 || bus.edit_mode !== 2'd0 || bus.hours_set !== 8'h09) begin
            mismatched++;
            $display("[TB] FAIL time_back_idle: got load=%b mode=%0d hours_set=%h expected 0/0/09",
                     bus.time_load, bus.edit_mode, bus.hours_set);
        end
    endtask

    task automatic test_alarm_edit();
        drive(1'b0, 1'b1, 3'd1, 8'h06, 8'h45);
        tick();
        compared++;
        if (bus.edit_mode !== 2'd2 || bus.alarm_hours !== 16'h0000) begin
            mismatched++;
            $display("[TB] FAIL alarm_entry: got mode=%0d alarm_hours=%h expected 2/0000", bus.edit_mode, bus.alarm_hours);
        end
        tick();
        bus.alarm_sel = 3'd0;
        tick(); tick();
        compared++;
        if (bus.alarm_hours !== 16'h0600 || bus.alarm_minutes !== 16'h4500) begin
            mismatched++;
            $display("[TB] FAIL alarm_channel_lock: got %h/%h expected 0600/4500", bus.alarm_hours, bus.alarm_minutes);
        end
        bus.set_alarm = 1'b0;
        tick();
        compared++;
        if (bus.edit_mode !== 2'd0 || bus.time_load !== 1'b0 || bus.alarm_hours !== 16'h0600) begin
            mismatched++;
            $display("[TB] FAIL alarm_exit: got mode=%0d load=%b alarm_hours=%h expected 0/0/0600",
                     bus.edit_mode, bus.time_load, bus.alarm_hours);
        end
    endtask

    task automatic test_bad_value();
        drive(1'b1, 1'b0, 3'd0, 8'h24, 8'h30);
        tick();
        tick();
        compared++;
        if (bus.bad_value !== 1'b1 || bus.hours_set !== 8'h09) begin
            mismatched++;
            $display("[TB] FAIL bad_hours: got bad=%b hours_set=%h expected 1/09", bus.bad_value, bus.hours_set);
        end
        drive(1'b1, 1'b0, 3'd0, 8'h09, 8'h5A);
        tick();
        compared++;
        if (bus.bad_value !== 1'b1 || bus.minutes_set !== 8'h30) begin
            mismatched++;
            $display("[TB] FAIL bad_minutes: got bad=%b minutes_set=%h expected 1/30", bus.bad_value, bus.minutes_set);
        end
        drive(1'b1, 1'b0, 3'd0, 8'h23, 8'h59);
        tick();
        compared++;
        if (bus.bad_value !== 1'b0 || bus.hours_set !== 8'h23 || bus.minutes_set !== 8'h59) begin
            mismatched++;
            $display("[TB] FAIL boundary_valid: got bad=%b %h/%h expected 0 23/59",
                     bus.bad_value, bus.hours_set, bus.minutes_set);
        end
        bus.set_time = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_conflict();
        drive(1'b1, 1'b0, 3'd0, 8'h12, 8'h34);
        tick();
        tick();
        bus.set_alarm = 1'b1;
        tick();
        compared++;
        if (bus.edit_mode !== 2'd3 || bus.time_load !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL conflict_enter: got mode=%0d load=%b expected 3/0", bus.edit_mode, bus.time_load);
        end
        bus.hours   = 8'h15;
        bus.minutes = 8'h00;
        tick();
        bus.set_time = 1'b0;
        tick();
        compared++;
        if (bus.edit_mode !== 2'd3 || bus.hours_set !== 8'h12 || bus.minutes_set !== 8'h34) begin
            mismatched++;
            $display("[TB] FAIL conflict_hold: got mode=%0d %h/%h expected 3 12/34",
                     bus.edit_mode, bus.hours_set, bus.minutes_set);
        end
        bus.set_alarm = 1'b0;
        tick();
        compared++;
        if (bus.edit_mode !== 2'd0 || bus.time_load !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL conflict_exit: got mode=%0d load=%b expected 0/0", bus.edit_mode, bus.time_load);
        end
    endtask

    task automatic test_sel_range();
        drive(1'b0, 1'b1, 3'd2, 8'h07, 8'h15);
        tick();
        compared++;
        if (bus.edit_mode !== 2'd3) begin
            mismatched++;
            $display("[TB] FAIL sel_out_of_range: got mode=%0d expected 3", bus.edit_mode);
        end
        tick();
        compared++;
        if (bus.alarm_hours !== 16'h0600 || bus.alarm_minutes !== 16'h4500) begin
            mismatched++;
            $display("[TB] FAIL sel_no_write: got %h/%h expected 0600/4500", bus.alarm_hours, bus.alarm_minutes);
        end
        bus.set_alarm = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        drive(1'b0, 1'b1, 3'd0, 8'h11, 8'h22);
        tick();
        tick();
        compared++;
        if (bus.alarm_hours !== 16'h0611 || bus.alarm_minutes !== 16'h4522) begin
            mismatched++;
            $display("[TB] FAIL alarm_ch0_write: got %h/%h expected 0611/4522", bus.alarm_hours, bus.alarm_minutes);
        end
        #10 reset_n = 1'b0;
        #1;
        compared++;
        if (bus.alarm_hours !== 16'h0000 || bus.alarm_minutes !== 16'h0000 ||
            bus.hours_set !== 8'h00 || bus.minutes_set !== 8'h00) begin
            mismatched++;
            $display("[TB] FAIL async_reset_regs: got %h/%h %h/%h expected all zero",
                     bus.alarm_hours, bus.alarm_minutes, bus.hours_set, bus.minutes_set);
        end
        compared++;
        if (bus.edit_mode !== 2'd0 || bus.time_load !== 1'b0 || bus.bad_value !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL async_reset_status: got mode=%0d load=%b bad=%b expected 0/0/0",
                     bus.edit_mode, bus.time_load, bus.bad_value);
        end
        drive(1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
        #15 reset_n = 1'b1;
        tick();
        tick();
        compared++;
        if (bus.edit_mode !== 2'd0 || bus.time_load !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL after_reset_idle: got mode=%0d load=%b expected 0/0", bus.edit_mode, bus.time_load);
        end
    endtask

    task automatic test_pulse_count();
        compared++;
        if (load_pulses !== 2) begin
            mismatched++;
            $display("[TB] FAIL time_load_pulses: got %0d expected 2", load_pulses);
        end
    endtask

    initial begin
        compared    = 0;
        mismatched  = 0;
        load_pulses = 0;
`ifdef TIME_TARGET_ALARM_ARM_EN
        bus.disarm = '0;
`endif
        test_reset();
        test_time_edit();
        test_alarm_edit();
        test_bad_value();
        test_conflict();
        test_sel_range();
        test_async_reset();
        test_pulse_count();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
